mvu_job_dispatcher: RTL and testbench



---
 rtl/mvu_job_dispatcher.sv | 163 ++++++++++++++++
 tb/tb_mvu_job_dispatcher.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_job_dispatcher.sv
// mvu_job_dispatcher
//   Per-channel job queue and launcher for NMVU matrix-vector units. The host
//   enqueues configuration words per channel. Each channel pops its next job
//   into a held cfg register, pulses start, then waits for done or a watchdog
//   abort. Completion sets a sticky irq and a timeout sets a sticky err.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   push_valid/mvu/cfg    host enqueue request, target channel, config word
//   push_ready            combinational: target channel exists and its queue is not full
//   timeout               watchdog limit in cycles (0 disables the watchdog)
//   done[i]               completion pulse from MVU i
//   irq_clr[i], err_clr[i] clear the sticky flags (a simultaneous set wins)
//   start[i]              one-cycle launch pulse, registered
//   cfg[i*CFGW +: CFGW]   active configuration of channel i
//   busy[i]               channel i is running a job
//   irq[i], err[i]        sticky completion / timeout flags
//   qcount[i*CW +: CW]    jobs queued but not yet launched on channel i
module mvu_job_dispatcher #(
  parameter int NMVU  = 8,
  parameter int CFGW  = 64,
  parameter int DEPTH = 4,
  parameter int TOUTW = 16,
  localparam int MW   = (NMVU > 1) ? $clog2(NMVU) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_valid,
  input  logic [MW-1:0]        push_mvu,
  input  logic [CFGW-1:0]      push_cfg,
  output logic                 push_ready,
  input  logic [TOUTW-1:0]     timeout,
  input  logic [NMVU-1:0]      done,
  input  logic [NMVU-1:0]      irq_clr,
  input  logic [NMVU-1:0]      err_clr,
  output logic [NMVU-1:0]      start,
  output logic [NMVU*CFGW-1:0] cfg,
  output logic [NMVU-1:0]      busy,
  output logic [NMVU-1:0]      irq,
  output logic [NMVU-1:0]      err,
  output logic [NMVU*CW-1:0]   qcount
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [NMVU-1:0] full;
  logic            push_in_range;

  // Readiness never anticipates a same-cycle pop: a full queue refuses.
  assign push_in_range = (32'(push_mvu) < NMVU);
  assign push_ready    = push_in_range && !full[push_mvu];

  genvar gi;
  generate
    for (gi = 0; gi < NMVU; gi++) begin : g_ch
      logic [CFGW-1:0]  mem [DEPTH];
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic [CW-1:0]    count_next;
      state_t           state_reg;
      state_t           state_next;
      logic [TOUTW-1:0] wd_reg;
      logic [TOUTW-1:0] wd_next;
      logic             start_reg;
      logic             irq_reg;
      logic             err_reg;
      logic [CFGW-1:0]  cfg_reg;
      logic             push_en;
      logic             done_ok;
      logic             tout_hit;
      logic             launch;

      assign push_en  = push_valid && push_ready && (push_mvu == MW'(gi));
      assign full[gi] = (count_reg == CW'(DEPTH));

      always_comb begin
        state_next = state_reg;
        wd_next    = wd_reg;
        launch     = 1'b0;
        done_ok    = 1'b0;
        tout_hit   = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (count_reg != '0) begin
              launch     = 1'b1;
              state_next = ST_RUN;
            end
          end
          ST_RUN: begin
            // A done coinciding with the start pulse belongs to no job of ours.
            done_ok  = done[gi] && !start_reg;
            tout_hit = !done_ok && (timeout != '0) && (wd_reg == timeout - TOUTW'(1));
            if (done_ok || tout_hit) begin
              if (count_reg != '0) begin
                launch = 1'b1;  // chain straight into the next job
              end else begin
                state_next = ST_IDLE;
              end
            end
            if (wd_reg != '1) begin
              wd_next = wd_reg + TOUTW'(1);
            end
          end
          default: state_next = ST_IDLE;
        endcase
        if (launch) begin
          wd_next = '0;
        end
        count_next = count_reg + CW'(push_en) - CW'(launch);
      end

      // Queue storage carries no reset; the pointers and count define validity.
      always_ff @(posedge clk) begin
        if (push_en) begin
          mem[wr_ptr_reg] <= push_cfg;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg  <= ST_IDLE;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          wd_reg     <= '0;
          start_reg  <= 1'b0;
          irq_reg    <= 1'b0;
          err_reg    <= 1'b0;
          cfg_reg    <= '0;
        end else begin
          state_reg <= state_next;
          count_reg <= count_next;
          wd_reg    <= wd_next;
          start_reg <= launch;
          if (push_en) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (launch) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            cfg_reg    <= mem[rd_ptr_reg];
          end
          irq_reg <= done_ok  | (irq_reg & ~irq_clr[gi]);
          err_reg <= tout_hit | (err_reg & ~err_clr[gi]);
        end
      end

      assign start[gi]                 = start_reg;
      assign busy[gi]                  = (state_reg == ST_RUN);
      assign irq[gi]                   = irq_reg;
      assign err[gi]                   = err_reg;
      assign cfg[gi*CFGW +: CFGW]      = cfg_reg;
      assign qcount[gi*CW +: CW]       = count_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Testbench for mvu_job_dispatcher. A scoreboard queue holds the expected
// configuration of every accepted job; a negedge monitor pops and compares it
// whenever a start pulse appears. Scenario tasks add inline checks.
module tb_mvu_job_dispatcher;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_valid;
  logic [2:0]    push_mvu;
  logic [63:0]   push_cfg;
  logic          push_ready;
  logic [15:0]   timeout;
  logic [7:0]    done, irq_clr, err_clr;
  logic [7:0]    start, busy, irq, err;
  logic [511:0]  cfg;
  logic [23:0]   qcount;

  // Small second instance: its channel count does not fill the index range,
  // so an out-of-range channel number can be presented.
  logic          push_valid2;
  logic [1:0]    push_mvu2;
  logic [63:0]   push_cfg2;
  logic          push_ready2;
  logic [15:0]   timeout2;
  logic [2:0]    done2, irq_clr2, err_clr2;
  logic [2:0]    start2, busy2, irq2, err2;
  logic [191:0]  cfg2;
  logic [8:0]    qcount2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          mvu;
    logic [63:0] cfg;
  } job_t;
  job_t sb[$];

  always #5 clk = ~clk;

  mvu_job_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_mvu(push_mvu), .push_cfg(push_cfg), .push_ready(push_ready),
    .timeout(timeout), .done(done), .irq_clr(irq_clr), .err_clr(err_clr),
    .start(start), .cfg(cfg), .busy(busy), .irq(irq), .err(err), .qcount(qcount)
  );

  mvu_job_dispatcher #(.NMVU(3)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid2), .push_mvu(push_mvu2), .push_cfg(push_cfg2), .push_ready(push_ready2),
    .timeout(timeout2), .done(done2), .irq_clr(irq_clr2), .err_clr(err_clr2),
    .start(start2), .cfg(cfg2), .busy(busy2), .irq(irq2), .err(err2), .qcount(qcount2)
  );

  // Scoreboard monitor: every start must match the oldest queued job of its channel.
  always @(negedge clk) begin
    int idx;
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (start[i]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].mvu == i) begin
              idx = k;
              break;
            end
          end
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL start_unexpected mvu=%0d got start with cfg=%h, required no start", i, cfg[i*64 +: 64]);
          end else begin
            if (cfg[i*64 +: 64] !== sb[idx].cfg) begin
              bad++;
              $display("FAIL start_cfg mvu=%0d got=%h required=%h", i, cfg[i*64 +: 64], sb[idx].cfg);
            end else begin
              $display("start mvu=%0d cfg=%h ok", i, cfg[i*64 +: 64]);
            end
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted push and record the expected job.
  task automatic push_job(input int m, input logic [63:0] c);
    push_valid = 1'b1;
    push_mvu   = 3'(m);
    push_cfg   = c;
    sb.push_back('{mvu: m, cfg: c});
    step();
    push_valid = 1'b0;
    $display("push mvu=%0d cfg=%h", m, c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push_valid = 0; push_mvu = 0; push_cfg = 0; timeout = 0;
    done = 0; irq_clr = 0; err_clr = 0;
    push_valid2 = 0; push_mvu2 = 0; push_cfg2 = 0; timeout2 = 0;
    done2 = 0; irq_clr2 = 0; err_clr2 = 0;
    repeat (3) step();
    total++;
    if ({start, busy, irq, err} !== 32'h0) begin
      bad++; $display("FAIL reset_flags got=%h required=0", {start, busy, irq, err});
    end
    total++;
    if (cfg !== 512'h0 || qcount !== 24'h0) begin
      bad++; $display("FAIL reset_cfg_qcount got qcount=%h required 0 (cfg nonzero=%0b)", qcount, cfg != 0);
    end
    total++;
    if (push_ready !== 1'b1) begin
      bad++; $display("FAIL reset_push_ready got=%b required=1", push_ready);
    end
    rst_n = 1'b1;
    step();
    $display("reset done");
  endtask

  task automatic test_single();
    push_job(2, 64'hA5A5);
    total++;
    if (qcount[6 +: 3] !== 3'd1 || start[2] !== 1'b0) begin
      bad++; $display("FAIL single_queued got qcount=%0d start=%b required 1/0", qcount[6 +: 3], start[2]);
    end
    step();
    total++;
    if (start[2] !== 1'b1 || busy[2] !== 1'b1 || qcount[6 +: 3] !== 3'd0 || cfg[128 +: 64] !== 64'hA5A5) begin
      bad++; $display("FAIL single_launch got start=%b busy=%b qcount=%0d cfg=%h required 1/1/0/a5a5",
                      start[2], busy[2], qcount[6 +: 3], cfg[128 +: 64]);
    end
    step();
    total++;
    if (start[2] !== 1'b0 || busy[2] !== 1'b1) begin
      bad++; $display("FAIL single_pulse got start=%b busy=%b required 0/1", start[2], busy[2]);
    end
    repeat (8) step();
    done[2] = 1'b1; step(); done[2] = 1'b0;
    total++;
    if (irq[2] !== 1'b1 || busy[2] !== 1'b0 || cfg[128 +: 64] !== 64'hA5A5) begin
      bad++; $display("FAIL single_done got irq=%b busy=%b cfg=%h required 1/0/a5a5", irq[2], busy[2], cfg[128 +: 64]);
    end
    irq_clr[2] = 1'b1; step(); irq_clr[2] = 1'b0;
    total++;
    if (irq[2] !== 1'b0) begin
      bad++; $display("FAIL single_irq_clr got irq=%b required 0", irq[2]);
    end
    $display("single job scenario done");
  endtask

  task automatic test_fill_chain();
    push_job(0, 64'h10);
    for (int k = 1; k <= 4; k++) push_job(0, 64'(k));
    total++;
    if (qcount[0 +: 3] !== 3'd4 || busy[0] !== 1'b1) begin
      bad++; $display("FAIL fill_qcount got qcount=%0d busy=%b required 4/1", qcount[0 +: 3], busy[0]);
    end
    push_valid = 1'b1; push_mvu = 3'd0; push_cfg = 64'h5;
    #1;
    total++;
    if (push_ready !== 1'b0) begin
      bad++; $display("FAIL fill_ready_full got=%b required=0", push_ready);
    end
    step();
    push_valid = 1'b0;
    total++;
    if (qcount[0 +: 3] !== 3'd4) begin
      bad++; $display("FAIL fill_refused got qcount=%0d required 4", qcount[0 +: 3]);
    end
    for (int k = 1; k <= 4; k++) begin
      done[0] = 1'b1; step(); done[0] = 1'b0;
      total++;
      if (start[0] !== 1'b1 || busy[0] !== 1'b1 || cfg[0 +: 64] !== 64'(k) || qcount[0 +: 3] !== 3'(4 - k)) begin
        bad++; $display("FAIL chain_%0d got start=%b busy=%b cfg=%h qcount=%0d required 1/1/%0d/%0d",
                        k, start[0], busy[0], cfg[0 +: 64], qcount[0 +: 3], k, 4 - k);
      end
      step(); step();
    end
    done[0] = 1'b1; step(); done[0] = 1'b0;
    total++;
    if (start[0] !== 1'b0 || busy[0] !== 1'b0 || irq[0] !== 1'b1) begin
      bad++; $display("FAIL chain_end got start=%b busy=%b irq=%b required 0/0/1", start[0], busy[0], irq[0]);
    end
    irq_clr[0] = 1'b1; step(); irq_clr[0] = 1'b0;
    $display("fill and chain scenario done");
  endtask

  task automatic test_timeout();
    timeout = 16'd5;
    push_job(0, 64'hB0);
    push_job(0, 64'hB1);
    total++;
    if (start[0] !== 1'b1 || err[0] !== 1'b0) begin
      bad++; $display("FAIL tout_launch got start=%b err=%b required 1/0", start[0], err[0]);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      total++;
      if (k < 5) begin
        if (err[0] !== 1'b0) begin
          bad++; $display("FAIL tout_early cycle=%0d got err=%b required 0", k, err[0]);
        end
      end else begin
        if (err[0] !== 1'b1 || irq[0] !== 1'b0 || start[0] !== 1'b1 || cfg[0 +: 64] !== 64'hB1) begin
          bad++; $display("FAIL tout_abort got err=%b irq=%b start=%b cfg=%h required 1/0/1/b1",
                          err[0], irq[0], start[0], cfg[0 +: 64]);
        end
      end
    end
    timeout = 16'd0;
    err_clr[0] = 1'b1; step(); err_clr[0] = 1'b0;
    total++;
    if (err[0] !== 1'b0) begin
      bad++; $display("FAIL tout_err_clr got err=%b required 0", err[0]);
    end
    repeat (30) step();
    total++;
    if (busy[0] !== 1'b1 || err[0] !== 1'b0) begin
      bad++; $display("FAIL tout_disabled got busy=%b err=%b required 1/0", busy[0], err[0]);
    end
    done[0] = 1'b1; step(); done[0] = 1'b0;
    total++;
    if (irq[0] !== 1'b1 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL tout_finish got irq=%b busy=%b required 1/0", irq[0], busy[0]);
    end
    irq_clr[0] = 1'b1; step(); irq_clr[0] = 1'b0;
    $display("timeout scenario done");
  endtask

  task automatic test_corners();
    push_job(3, 64'hC0);
    step();
    done[3] = 1'b1; step(); done[3] = 1'b0;
    total++;
    if (irq[3] !== 1'b0 || busy[3] !== 1'b1) begin
      bad++; $display("FAIL corner_done_with_start got irq=%b busy=%b required 0/1", irq[3], busy[3]);
    end
    step();
    done[3] = 1'b1; step(); done[3] = 1'b0;
    total++;
    if (irq[3] !== 1'b1 || busy[3] !== 1'b0) begin
      bad++; $display("FAIL corner_done got irq=%b busy=%b required 1/0", irq[3], busy[3]);
    end
    push_job(3, 64'hC1);
    step(); step();
    done[3] = 1'b1; irq_clr[3] = 1'b1; step(); done[3] = 1'b0; irq_clr[3] = 1'b0;
    total++;
    if (irq[3] !== 1'b1) begin
      bad++; $display("FAIL corner_set_wins got irq=%b required 1", irq[3]);
    end
    irq_clr[3] = 1'b1; step(); irq_clr[3] = 1'b0;
    done[3] = 1'b1; step(); done[3] = 1'b0;
    total++;
    if (irq[3] !== 1'b0 || busy[3] !== 1'b0) begin
      bad++; $display("FAIL corner_done_idle got irq=%b busy=%b required 0/0", irq[3], busy[3]);
    end
    push_valid2 = 1'b1; push_mvu2 = 2'd3; push_cfg2 = 64'hDEAD;
    #1;
    total++;
    if (push_ready2 !== 1'b0) begin
      bad++; $display("FAIL corner_range_ready got=%b required=0", push_ready2);
    end
    push_mvu2 = 2'd2;
    #1;
    total++;
    if (push_ready2 !== 1'b1) begin
      bad++; $display("FAIL corner_inrange_ready got=%b required=1", push_ready2);
    end
    push_mvu2 = 2'd3;
    step();
    push_valid2 = 1'b0;
    step();
    total++;
    if (qcount2 !== 9'd0 || start2 !== 3'd0 || busy2 !== 3'd0) begin
      bad++; $display("FAIL corner_range_write got qcount=%h start=%b busy=%b required 0/0/0", qcount2, start2, busy2);
    end
    $display("corner scenario done");
  endtask

  task automatic test_independence_reset();
    push_job(0, 64'hD0);
    push_job(7, 64'hD7);
    step(); step();
    done[7] = 1'b1; step(); done[7] = 1'b0;
    total++;
    if (irq[7] !== 1'b1 || busy[7] !== 1'b0 || busy[0] !== 1'b1 || irq[0] !== 1'b0) begin
      bad++; $display("FAIL indep_ch7 got irq7=%b busy7=%b busy0=%b irq0=%b required 1/0/1/0", irq[7], busy[7], busy[0], irq[0]);
    end
    step(); step(); step();
    done[0] = 1'b1; step(); done[0] = 1'b0;
    total++;
    if (irq[0] !== 1'b1 || busy[0] !== 1'b0 || cfg[0 +: 64] !== 64'hD0 || cfg[448 +: 64] !== 64'hD7) begin
      bad++; $display("FAIL indep_ch0 got irq0=%b busy0=%b cfg0=%h cfg7=%h required 1/0/d0/d7",
                      irq[0], busy[0], cfg[0 +: 64], cfg[448 +: 64]);
    end
    irq_clr = 8'h81; step(); irq_clr = 8'h00;
    push_job(0, 64'hE0);
    push_job(0, 64'hE1);
    push_job(7, 64'hE7);
    step();
    done[0] = 1'b1; step(); done[0] = 1'b0;
    total++;
    if (irq[0] !== 1'b1 || start[0] !== 1'b1 || busy[7] !== 1'b1) begin
      bad++; $display("FAIL reset_prep got irq0=%b start0=%b busy7=%b required 1/1/1", irq[0], start[0], busy[7]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({start, busy, irq, err} !== 32'h0 || qcount !== 24'h0 || cfg !== 512'h0) begin
      bad++; $display("FAIL reset_midrun got flags=%h qcount=%h required 0/0", {start, busy, irq, err}, qcount);
    end
    sb.delete();
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (start !== 8'h0 || busy !== 8'h0) begin
        bad++; $display("FAIL reset_no_resume cycle=%0d got start=%h busy=%h required 0/0", k, start, busy);
      end
    end
    push_job(7, 64'hF7);
    step();
    total++;
    if (start[7] !== 1'b1 || cfg[448 +: 64] !== 64'hF7) begin
      bad++; $display("FAIL reset_new_push got start=%b cfg=%h required 1/f7", start[7], cfg[448 +: 64]);
    end
    done[7] = 1'b1; step(); step(); done[7] = 1'b0;
    irq_clr[7] = 1'b1; step(); irq_clr[7] = 1'b0;
    $display("independence and reset scenario done");
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_chain();
    test_timeout();
    test_corners();
    test_independence_reset();
    step(); step();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got %0d pending jobs required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
